// File: rtl/fifo_rd_packer_if.sv
// Read-side packer bus: FIFO show-ahead port on one side, packed valid/ready word on the other.
interface fifo_rd_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
);
    logic [DATA_WIDTH-1:0]      i_rdata;
    logic                       i_rempty;
    logic                       o_rinc;
    logic [DATA_WIDTH*PACK-1:0] o_word;
    logic [$clog2(PACK+1)-1:0]  o_count;
    logic                       o_valid;
    logic                       i_ready;
    logic                       o_busy;

    modport master (
        input  i_rdata, i_rempty, i_ready,
        output o_rinc, o_word, o_count, o_valid, o_busy
    );

    modport slave (
        output i_rdata, i_rempty, i_ready,
        input  o_rinc, o_word, o_count, o_valid, o_busy
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops PACK bytes from a show-ahead async FIFO read port and presents them as one word on valid/ready.
// Optional partial-word flush after TIMEOUT_CYCLES idle cycles: define FIFO_RD_PACKER_TIMEOUT_EN.
module fifo_rd_packer #(
    parameter int DATA_WIDTH     = 8,
    parameter int PACK           = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    fifo_rd_packer_if.master bus
);
    localparam int LW = $clog2(PACK);
    localparam int CW = $clog2(PACK + 1);
    localparam int WW = DATA_WIDTH * PACK;

    if (PACK < 2) begin : g_bad_pack
        $error("PACK must be >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    state_t          state, state_nxt;
    logic [LW-1:0]   lane, lane_nxt;
    logic [WW-1:0]   word, word_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic            valid, valid_nxt;
    logic            pop;

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_CYCLES);

    logic [IW-1:0] idle, idle_nxt;

    function automatic logic [IW-1:0] idle_sat_inc(input logic [IW-1:0] v);
        return (v == IDLE_LIMIT) ? v : v + 1'b1;
    endfunction
`endif

    // Pop never depends on i_ready; HOLD blocks pops even on the accept cycle.
    assign pop         = !i_rst && !bus.i_rempty && (state != HOLD);
    assign bus.o_rinc  = pop;
    assign bus.o_word  = word;
    assign bus.o_count = count;
    assign bus.o_valid = valid;
    assign bus.o_busy  = (state != IDLE);

    always_comb begin
        state_nxt = state;
        lane_nxt  = lane;
        word_nxt  = word;
        count_nxt = count;
        valid_nxt = valid;
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
        idle_nxt  = '0;
`endif
        case (state)
            IDLE, FILL: begin
                if (pop) begin
                    word_nxt[int'(lane)*DATA_WIDTH +: DATA_WIDTH] = bus.i_rdata;
                    if (lane == LW'(PACK - 1)) begin
                        lane_nxt  = '0;
                        count_nxt = CW'(PACK);
                        valid_nxt = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        lane_nxt  = lane + 1'b1;
                        state_nxt = FILL;
                    end
                end
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
                else if (state == FILL) begin
                    // Unfilled lanes are already zero: word is cleared on every accept and on reset.
                    if (idle == IDLE_LIMIT) begin
                        count_nxt = CW'(lane);
                        lane_nxt  = '0;
                        valid_nxt = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        idle_nxt = idle_sat_inc(idle);
                    end
                end
`endif
            end
            HOLD: begin
                if (bus.i_ready) begin
                    valid_nxt = 1'b0;
                    word_nxt  = '0;
                    count_nxt = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                lane_nxt  = '0;
                word_nxt  = '0;
                count_nxt = '0;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            lane  <= '0;
            word  <= '0;
            count <= '0;
            valid <= 1'b0;
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
            idle  <= '0;
`endif
        end else begin
            state <= state_nxt;
            lane  <= lane_nxt;
            word  <= word_nxt;
            count <= count_nxt;
            valid <= valid_nxt;
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
            idle  <= idle_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a queue-based show-ahead FIFO model.
module tb_fifo_rd_packer;
    localparam int DW = 8;
    localparam int PK = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;

    fifo_rd_packer_if #(.DATA_WIDTH(DW), .PACK(PK)) bus ();

    fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    logic [7:0] q[$];
    logic       gap = 1'b0;
    int         pops = 0;
    int         npass = 0;
    int         ntotal = 0;

    task automatic drive();
        bus.i_rempty = gap || (q.size() == 0);
        bus.i_rdata  = (q.size() != 0) ? q[0] : '0;
    endtask

    // One clock: pop decision sampled mid-cycle, model updated and settled just after the edge.
    task automatic tick();
        logic       popped;
        logic [7:0] dummy;
        @(negedge clk);
        popped = bus.o_rinc;
        @(posedge clk);
        #1;
        if (popped) begin
            dummy = q.pop_front();
            pops++;
        end
        drive();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_gap(input logic v);
        gap = v;
        drive();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntotal++;
        assert (got === exp) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    initial begin
        rst = 1'b1;
        bus.i_ready = 1'b1;
        q = '{8'h11, 8'h22, 8'h33, 8'h44,
              8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        drive();
        #1;

        // Reset with a non-empty FIFO
        chk("rst_rinc0", 64'(bus.o_rinc), 64'd0);
        ticks(2);
        chk("rst_rinc", 64'(bus.o_rinc), 64'd0);
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_word", 64'(bus.o_word), 64'd0);
        chk("rst_count", 64'(bus.o_count), 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_pops", 64'(pops), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_rinc", 64'(bus.o_rinc), 64'd1);

        // Basic pack
        ticks(3);
        chk("b_notyet", 64'(bus.o_valid), 64'd0);
        chk("b_busy", 64'(bus.o_busy), 64'd1);
        tick();
        chk("b_valid", 64'(bus.o_valid), 64'd1);
        chk("b_word", 64'(bus.o_word), 64'h44332211);
        chk("b_count", 64'(bus.o_count), 64'd4);
        chk("b_rinc_hold", 64'(bus.o_rinc), 64'd0);
        chk("b_pops", 64'(pops), 64'd4);
        tick();
        chk("b_valid_1cyc", 64'(bus.o_valid), 64'd0);
        chk("b_word_clr", 64'(bus.o_word), 64'd0);
        chk("b_count_clr", 64'(bus.o_count), 64'd0);
        chk("b_idle", 64'(bus.o_busy), 64'd0);

        // Backpressure
        bus.i_ready = 1'b0;
        ticks(4);
        chk("bp_valid1", 64'(bus.o_valid), 64'd1);
        chk("bp_word1", 64'(bus.o_word), 64'h04030201);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", 64'(bus.o_valid), 64'd1);
            chk("bp_hold_word", 64'(bus.o_word), 64'h04030201);
            chk("bp_hold_rinc", 64'(bus.o_rinc), 64'd0);
        end
        chk("bp_hold_pops", 64'(pops), 64'd8);
        bus.i_ready = 1'b1;
        tick();
        chk("bp_accept", 64'(bus.o_valid), 64'd0);
        ticks(4);
        chk("bp_valid2", 64'(bus.o_valid), 64'd1);
        chk("bp_word2", 64'(bus.o_word), 64'h08070605);
        chk("bp_count2", 64'(bus.o_count), 64'd4);
        chk("bp_pops", 64'(pops), 64'd12);
        tick();

        // Empty gap between 2nd and 3rd byte
        q.push_back(8'hA1); q.push_back(8'hA2); q.push_back(8'hA3); q.push_back(8'hA4);
        drive();
        #1;
        ticks(2);
        chk("g_busy", 64'(bus.o_busy), 64'd1);
        set_gap(1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("g_rinc", 64'(bus.o_rinc), 64'd0);
            tick();
            chk("g_valid", 64'(bus.o_valid), 64'd0);
        end
        chk("g_pops", 64'(pops), 64'd14);
        set_gap(1'b0);
        ticks(2);
        chk("g_valid_w", 64'(bus.o_valid), 64'd1);
        chk("g_word", 64'(bus.o_word), 64'hA4A3A2A1);
        chk("g_count", 64'(bus.o_count), 64'd4);
        tick();

        // Mid-operation reset discards partial data
        q.push_back(8'hAA); q.push_back(8'hBB);
        drive();
        #1;
        ticks(2);
        chk("mr_busy", 64'(bus.o_busy), 64'd1);
        chk("mr_pops", 64'(pops), 64'd18);
        rst = 1'b1;
        #1;
        chk("mr_async_busy", 64'(bus.o_busy), 64'd0);
        chk("mr_async_word", 64'(bus.o_word), 64'd0);
        chk("mr_async_valid", 64'(bus.o_valid), 64'd0);
        tick();
        rst = 1'b0;
        q.push_back(8'hC1); q.push_back(8'hC2); q.push_back(8'hC3); q.push_back(8'hC4);
        drive();
        #1;
        ticks(3);
        chk("mr_notyet", 64'(bus.o_valid), 64'd0);
        tick();
        chk("mr_valid", 64'(bus.o_valid), 64'd1);
        chk("mr_word", 64'(bus.o_word), 64'hC4C3C2C1);
        chk("mr_count", 64'(bus.o_count), 64'd4);
        tick();

        // Partial word followed by a long empty stretch
        q.push_back(8'h5A); q.push_back(8'h6B);
        drive();
        #1;
        ticks(2);
        chk("to_busy", 64'(bus.o_busy), 64'd1);
        ticks(TO);
        chk("to_before", 64'(bus.o_valid), 64'd0);
        tick();
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
        chk("to_valid", 64'(bus.o_valid), 64'd1);
        chk("to_word", 64'(bus.o_word), 64'h00006B5A);
        chk("to_count", 64'(bus.o_count), 64'd2);
        tick();
        chk("to_accept", 64'(bus.o_valid), 64'd0);
        chk("to_idle", 64'(bus.o_busy), 64'd0);
`else
        ticks(8);
        chk("nto_valid", 64'(bus.o_valid), 64'd0);
        chk("nto_busy", 64'(bus.o_busy), 64'd1);
`endif

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side consumer for the async FIFO read port, in the read clock domain.
- Pops bytes through the show-ahead interface (o_rdata is valid whenever o_rempty is low; a pop happens when rinc is high and empty is low) and packs PACK consecutive bytes into one wide word.
- Presents each word downstream on a valid/ready handshake.
- Provides controlled backpressure toward the FIFO, so the FIFO's own full/empty logic governs flow.

Parameters:
- DATA_WIDTH, 8, width of one FIFO entry (lane width).
- PACK, 4, lanes per output word; must be >= 2.
- TIMEOUT_CYCLES, 16, idle cycles before a partial word is flushed (used only with the optional feature); must be >= 1.

Ports:
- i_clk  input  1  read-domain clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_rdata  input  DATA_WIDTH  FIFO head data; valid when i_rempty = 0.
- i_rempty  input  1  FIFO empty flag.
- o_rinc  output  1  pop request to the FIFO; combinational.
- o_word  output  DATA_WIDTH*PACK  packed word; lane k is bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_count  output  $clog2(PACK+1)  number of valid lanes in o_word; meaningful while o_valid = 1.
- o_valid  output  1  o_word is valid.
- i_ready  input  1  downstream accepts o_word.
- o_busy  output  1  high when the state is not IDLE.

Behaviour:
- Reset (asynchronous, while i_rst = 1):
  - state = IDLE, lane counter = 0, idle counter = 0.
  - o_word = 0, o_count = 0, o_valid = 0, o_busy = 0.
  - o_rinc is forced to 0.
  - Reset in any state discards partial or held data; no word is emitted.
- States: IDLE (no lanes filled), FILL (1..PACK-1 lanes filled), HOLD (word presented, o_valid = 1).
- Pop rule: o_rinc = !i_rst && !i_rempty && (state != HOLD). o_rinc has no combinational path from i_ready. Pop occurs on a cycle where o_rinc = 1.
- On a pop, lane L = lane counter, and o_word lane L <= i_rdata on the same edge.
  - If L < PACK-1: lane counter <= L+1, state <= FILL.
  - If L = PACK-1: lane counter <= 0, o_count <= PACK, o_valid <= 1, state <= HOLD.
- Lane ordering is little-endian: the first byte popped lands in lane 0.
- HOLD:
  - o_word and o_count are stable while o_valid = 1 and i_ready = 0.
  - When i_ready = 1: o_valid <= 0, o_word <= 0 (unused lanes of the next partial word read as 0), o_count <= 0, state <= IDLE.
  - No pop is permitted in the HOLD cycle, including the accept cycle.
- Latency and throughput:
  - First pop to o_valid is PACK cycles when the FIFO is non-empty.
  - Peak rate is PACK bytes per PACK+1 cycles when i_ready is tied high.
- i_rempty = 1 in IDLE or FILL: no pop, and state is unchanged (apart from the timeout in the optional feature).
- Width rules:
  - The lane counter is $clog2(PACK) bits and wraps only via the explicit clear at L = PACK-1.
  - The idle counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates.
- o_busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro: FIFO_RD_PACKER_TIMEOUT_EN.
- Defined:
  - In FILL, the idle counter increments on each cycle without a pop and clears to 0 on a pop or on leaving FILL.
  - When it reaches TIMEOUT_CYCLES, the next edge moves the block to HOLD with o_count = current lane counter (1..PACK-1), o_valid = 1 and unfilled lanes = 0; the lane counter is cleared.
  - A pop on the same cycle the limit is reached takes priority: the byte is packed and the counter clears.
- Undefined: no idle counter exists, partial words wait indefinitely, and o_count always equals PACK when o_valid = 1.

Test Plan:
- Reset sanity: assert i_rst with the FIFO non-empty (i_rempty = 0) -> o_rinc = 0, o_valid = 0, o_word = 0, o_count = 0 throughout; release -> o_rinc = 1 on the next cycle.
- Basic pack: FIFO preloaded with 0x11, 0x22, 0x33, 0x44, i_ready = 1 -> o_word = 0x44332211, o_count = 4 on the 4th edge after the first pop; o_valid is high for exactly 1 cycle; o_rinc is low in that cycle.
- Backpressure: 8 bytes 0x01..0x08, i_ready = 0 for 5 cycles after the first word -> o_word = 0x04030201 held stable; no pops while held; after i_ready rises the second word is 0x08070605; exactly 8 pops total.
- Empty gaps: bytes arrive with i_rempty = 1 for 3 cycles between the 2nd and 3rd byte -> no pops during the gap; the word still equals the in-order bytes, with o_count = 4.
- Mid-operation reset: pop 0xAA, 0xBB, then pulse i_rst, then supply 0xC1..0xC4 -> the only word emitted is 0xC4C3C2C1; 0xAA and 0xBB never appear.
- FIFO_RD_PACKER_TIMEOUT_EN with TIMEOUT_CYCLES = 16: push 0x5A, 0x6B, then empty for 16 cycles -> o_valid with o_word = 0x00006B5A, o_count = 2. Without the macro, the same stimulus leaves o_valid = 0 indefinitely.
